load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_extend.sv | 24 ++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: access size
// encodings, FSM state type and a size-to-byte-count helper.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      RESP = 2'b10
   } lsu_state_t;

   // Reserved size maps to 0 bytes; such requests never reach XFER.
   function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
      logic [2:0] n;
      n = 3'd0;
      case (sz)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         SZ_WORD: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: takes the big-endian byte accumulator and
// sign- or zero-extends the sized value to 32 bits.
// Ports: i_size (access size), i_signed (1 = sign-extend),
//        i_acc (accumulated bytes, LSB-justified), o_result (32-bit value).
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_acc,
   output logic [31:0] o_result
);

   always_comb begin
      o_result = '0;
      case (i_size)
         SZ_BYTE: o_result = {{24{i_signed & i_acc[7]}}, i_acc[7:0]};
         SZ_HALF: o_result = {{16{i_signed & i_acc[15]}}, i_acc[15:0]};
         SZ_WORD: o_result = i_acc;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit in front of an 8-bit RAM with combinational
// read. Accesses are big-endian, one byte per cycle, one request in flight.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses.
// Ports: CLK, RST (async, active-high); req_* request channel with
//        valid/ready; resp_valid/resp_rdata/resp_err one-cycle response;
//        mem_addr/mem_we/mem_wdata/mem_rdata byte RAM interface.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   lsu_state_t  r_state;
   logic [1:0]  r_idx;
   logic [1:0]  r_last;
   logic        r_rw;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [23:0] r_acc;
   logic [31:0] r_wsh;
   logic [31:0] r_mem_addr;
   logic        r_mem_we;
   logic [7:0]  r_mem_wdata;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic [31:0] r_resp_rdata;

   logic [2:0]  w_nbytes;
   logic [32:0] w_end;
   logic        w_oob;
   logic        w_misalign;
   logic        w_illegal;
   logic [31:0] w_walign;
   logic [31:0] w_acc_next;
   logic [31:0] w_ext;

   assign w_nbytes = size_nbytes(req_size);

   // 33-bit end address so a request near 2^32 cannot wrap into range.
   assign w_end = {1'b0, req_addr} + {30'd0, w_nbytes};
   assign w_oob = w_end > 33'(MEM_BYTES);

`ifdef LSU_ALIGN_CHECK_EN
   assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                       ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_illegal = (req_size == SZ_RSVD) || w_oob || w_misalign;

   // Store data left-justified so the next byte out is always [31:24].
   always_comb begin
      w_walign = '0;
      if (req_rw) begin
         case (req_size)
            SZ_BYTE: w_walign = {req_wdata[7:0], 24'd0};
            SZ_HALF: w_walign = {req_wdata[15:0], 16'd0};
            SZ_WORD: w_walign = req_wdata;
            default: w_walign = '0;
         endcase
      end
   end

   assign w_acc_next = {r_acc, mem_rdata};

   lsu_extend u_extend (
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_acc    (w_acc_next),
      .o_result (w_ext)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_last       <= '0;
         r_rw         <= 1'b0;
         r_size       <= SZ_BYTE;
         r_signed     <= 1'b0;
         r_acc        <= '0;
         r_wsh        <= '0;
         r_mem_addr   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
               if (req_valid) begin
                  r_rw     <= req_rw;
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_acc    <= '0;
                  r_idx    <= '0;
                  r_last   <= 2'(w_nbytes - 3'd1);
                  if (w_illegal) begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else begin
                     // Byte 0 presented to the RAM in the first XFER cycle.
                     r_state     <= XFER;
                     r_mem_addr  <= req_addr;
                     r_mem_we    <= req_rw;
                     r_mem_wdata <= w_walign[31:24];
                     r_wsh       <= {w_walign[23:0], 8'd0};
                  end
               end
            end
            XFER: begin
               r_acc <= w_acc_next[23:0];
               if (r_idx == r_last) begin
                  r_state      <= RESP;
                  r_mem_addr   <= '0;
                  r_mem_we     <= 1'b0;
                  r_mem_wdata  <= '0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= r_rw ? 32'd0 : w_ext;
               end else begin
                  r_idx       <= r_idx + 2'd1;
                  r_mem_addr  <= r_mem_addr + 32'd1;
                  r_mem_wdata <= r_wsh[31:24];
                  r_wsh       <= {r_wsh[23:0], 8'd0};
               end
            end
            RESP: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b0;
               r_resp_err   <= 1'b0;
               r_resp_rdata <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte RAM model, directed
// scenarios, then random requests checked against a byte-array model.
module tb_load_store_unit;

   localparam int MEMB = 256;
`ifdef LSU_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0] ram [MEMB];
   bit   [7:0] ref_mem [MEMB];
   bit         load_ram;
   int         n_assert = 0;
   int         n_fail = 0;

   always #5 CLK = ~CLK;

   load_store_unit #(.MEM_BYTES(MEMB)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rw     (req_rw),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = (mem_addr < MEMB) ? ram[mem_addr[7:0]] : 8'h00;

   always @(posedge CLK) begin
      if (load_ram) begin
         for (int i = 0; i < MEMB; i++) ram[i] <= ref_mem[i];
      end else if (mem_we && mem_addr < MEMB) begin
         ram[mem_addr[7:0]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic txn(input string tag, input bit rw, input bit [1:0] sz,
                      input bit sg, input bit [31:0] addr,
                      input bit [31:0] wd, output logic [31:0] rd);
      int nb;
      bit legal;
      longint val;
      bit [31:0] exp_rd;
      int exp_lat;
      int cyc;
      bit [7:0] eb;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      legal = (sz != 2'd3) && (longint'(addr) + nb <= MEMB);
      if (ALIGN && ((sz == 2'd1 && addr % 2 != 0) ||
                    (sz == 2'd2 && addr % 4 != 0)))
         legal = 1'b0;
      exp_rd = 32'd0;
      if (legal && !rw) begin
         val = 0;
         for (int i = 0; i < nb; i++) val = val * 256 + ref_mem[addr + i];
         if (sg && val >= (longint'(1) << (8 * nb - 1)))
            val -= (longint'(1) << (8 * nb));
         exp_rd = 32'(val);
      end
      exp_lat = legal ? nb + 1 : 1;

      @(negedge CLK);
      req_rw = rw; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      @(negedge CLK);
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom;
      req_size = 2'($urandom); req_rw = 1'($urandom);
      cyc = 1;
      while (resp_valid !== 1'b1 && cyc <= 8) begin
         if (legal && cyc <= nb) begin
            chk({tag, " maddr"}, mem_addr, addr + 32'(cyc - 1));
            chk({tag, " mwe"}, {31'd0, mem_we}, {31'd0, rw});
            if (rw) begin
               eb = 8'((wd >> (8 * (nb - cyc))) & 32'hFF);
               chk({tag, " mwdata"}, {24'd0, mem_wdata}, {24'd0, eb});
            end
         end else begin
            chk({tag, " idle mwe"}, {31'd0, mem_we}, 32'd0);
            chk({tag, " idle maddr"}, mem_addr, 32'd0);
         end
         chk({tag, " busy ready"}, {31'd0, req_ready}, 32'd0);
         @(negedge CLK);
         cyc++;
      end
      chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, " err"}, {31'd0, resp_err}, {31'd0, !legal});
      chk({tag, " rdata"}, resp_rdata, exp_rd);
      chk({tag, " resp mwe"}, {31'd0, mem_we}, 32'd0);
      chk({tag, " resp maddr"}, mem_addr, 32'd0);
      rd = resp_rdata;
      if (legal && rw)
         for (int i = 0; i < nb; i++)
            ref_mem[addr + i] = 8'((wd >> (8 * (nb - 1 - i))) & 32'hFF);
      @(negedge CLK);
      chk({tag, " resp 1cyc"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, " ready after"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      bit [7:0] p32, p33;
      bit [31:0] ra;
      bit [1:0] rs;
      int saw, diffs;

      RST = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; load_ram = 1'b1;
      for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'($urandom);
      #2;
      chk("rst ready", {31'd0, req_ready}, 32'd1);
      chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst rdata", resp_rdata, 32'd0);
      chk("rst mwe", {31'd0, mem_we}, 32'd0);
      chk("rst maddr", mem_addr, 32'd0);
      chk("rst mwdata", {24'd0, mem_wdata}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      load_ram = 1'b0;
      RST = 1'b0;

      txn("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd);
      chk("ram10", {24'd0, ram[8'h10]}, 32'h11);
      chk("ram11", {24'd0, ram[8'h11]}, 32'h22);
      chk("ram12", {24'd0, ram[8'h12]}, 32'h33);
      chk("ram13", {24'd0, ram[8'h13]}, 32'h44);
      txn("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
      chk("ld_w10 const", rd, 32'h11223344);

      txn("st_b20", 1'b1, 2'd0, 1'b0, 32'h20, 32'hABCDEF80, rd);
      txn("ld_bs20", 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, rd);
      chk("ld_bs20 const", rd, 32'hFFFFFF80);
      txn("ld_bu20", 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, rd);
      chk("ld_bu20 const", rd, 32'h00000080);

      txn("ld_wFE", 1'b0, 2'd2, 1'b0, 32'hFE, 32'h0, rd);
      txn("ld_wFC", 1'b0, 2'd2, 1'b1, 32'hFC, 32'h0, rd);
      txn("ld_bFF", 1'b0, 2'd0, 1'b1, 32'hFF, 32'h0, rd);
      txn("ld_hFF", 1'b0, 2'd1, 1'b0, 32'hFF, 32'h0, rd);
      txn("st_wwrap", 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h12345678, rd);
      txn("ld_rsvd", 1'b0, 2'd3, 1'b0, 32'h04, 32'h0, rd);
      txn("st_h40", 1'b1, 2'd1, 1'b0, 32'h40, 32'hDEADBEEF, rd);
      chk("ram40", {24'd0, ram[8'h40]}, 32'hBE);
      chk("ram41", {24'd0, ram[8'h41]}, 32'hEF);

      txn("st_b21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h9A, rd);
      txn("st_b22", 1'b1, 2'd0, 1'b0, 32'h22, 32'h5B, rd);
      txn("ld_hs21", 1'b0, 2'd1, 1'b1, 32'h21, 32'h0, rd);
      chk("ld_hs21 const", rd, ALIGN ? 32'h0 : 32'hFFFF9A5B);

      p32 = ref_mem[8'h32];
      p33 = ref_mem[8'h33];
      @(negedge CLK);
      req_rw = 1'b1; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h30; req_wdata = 32'hA1B2C3D4; req_valid = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      chk("rx xfer0 maddr", mem_addr, 32'h30);
      @(negedge CLK);
      chk("rx xfer1 maddr", mem_addr, 32'h31);
      RST = 1'b1;
      #1;
      chk("rx mwe", {31'd0, mem_we}, 32'd0);
      chk("rx maddr", mem_addr, 32'd0);
      chk("rx mwdata", {24'd0, mem_wdata}, 32'd0);
      chk("rx resp_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      saw = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (resp_valid !== 1'b0) saw++;
      end
      chk("rx no resp", 32'(saw), 32'd0);
      chk("rx ready", {31'd0, req_ready}, 32'd1);
      chk("rx ram30", {24'd0, ram[8'h30]}, 32'hA1);
      chk("rx ram32", {24'd0, ram[8'h32]}, {24'd0, p32});
      chk("rx ram33", {24'd0, ram[8'h33]}, {24'd0, p33});
      ref_mem[8'h30] = 8'hA1;
      ref_mem[8'h31] = ram[8'h31];

      for (int n = 0; n < 80; n++) begin
         rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(248, 255));
         else ra = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) ra = ra & ~32'h3;
         txn("rnd", 1'($urandom), rs, 1'($urandom), ra, $urandom, rd);
      end

      diffs = 0;
      for (int i = 0; i < MEMB; i++)
         if (ram[i] !== ref_mem[i]) diffs++;
      chk("ram final diffs", 32'(diffs), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
